// File: rtl/local_inject_arbiter.sv
`default_nettype none
// ============================================================================
// local_inject_arbiter : per-source packet FIFOs, round-robin injection onto
//                        the local (port 0) input of one mesh router node.
// Rev 1.0
// ============================================================================
module local_inject_arbiter #(
  parameter int N_SRC      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int DATA_W     = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [0:N_SRC-1][DATA_W-1:0] i_src_data,
  input  logic [0:N_SRC-1]             i_src_val,
  output logic [0:N_SRC-1]             o_src_ready,
  input  logic [3:0]                   i_net_en,
  output logic [DATA_W-1:0]            o_data,
  output logic                         o_data_val,
  output logic [0:N_SRC-1]             o_grant,
  output logic [CNT_W-1:0]             o_inj_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int SEL_W = $clog2(N_SRC);
  localparam logic [OCC_W-1:0] C_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [SEL_W:0]   C_NSRC = (SEL_W + 1)'(N_SRC);
  localparam logic [SEL_W-1:0] C_LAST = SEL_W'(N_SRC - 1);

  logic [DATA_W-1:0] head [N_SRC];
  logic [N_SRC-1:0]  eligible;
  logic [N_SRC-1:0]  pop;

  genvar k;
  generate
    for (k = 0; k < N_SRC; k++) begin : g_fifo
      logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
      logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
      logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
      logic [OCC_W-1:0]  occ_q, occ_d;
      logic              push;

      assign push = i_src_val[k] && (occ_q < C_FULL);

      always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
          mem_d[wr_ptr_q] = i_src_data[k];
          wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop[k]) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop[k]) begin
          occ_d = occ_q + OCC_W'(1);
        end else if (!push && pop[k]) begin
          occ_d = occ_q - OCC_W'(1);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          occ_q    <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          occ_q    <= occ_d;
        end
      end

      // Storage needs no reset: occupancy alone decides what is readable.
      always_ff @(posedge clk) begin
        mem_q <= mem_d;
      end

      assign head[k]        = mem_q[rd_ptr_q];
      assign eligible[k]    = (occ_q != '0);
      assign o_src_ready[k] = (occ_q < C_FULL);
    end
  endgenerate

  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic [SEL_W:0]    cand;
  logic [DATA_W-1:0] data_q, data_d;
  logic              data_val_q, data_val_d;
  logic [0:N_SRC-1]  grant_q, grant_d;
  logic [CNT_W-1:0]  inj_cnt_q, inj_cnt_d;

  // Scan downwards so the last hit, i.e. the one nearest rr_ptr, wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (|i_net_en) begin
      for (int i = N_SRC - 1; i >= 0; i--) begin
        cand = {1'b0, rr_ptr_q} + (SEL_W + 1)'(i);
        if (cand >= C_NSRC) begin
          cand = cand - C_NSRC;
        end
        if (eligible[cand[SEL_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    if (gnt_vld) begin
      pop[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    data_d     = data_q;
    data_val_d = gnt_vld;
    grant_d    = '0;
    rr_ptr_d   = rr_ptr_q;
    inj_cnt_d  = inj_cnt_q;
    if (gnt_vld) begin
      data_d           = head[gnt_idx];
      grant_d[gnt_idx] = 1'b1;
      rr_ptr_d         = (gnt_idx == C_LAST) ? '0 : gnt_idx + SEL_W'(1);
      inj_cnt_d        = inj_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= '0;
      data_val_q <= 1'b0;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      inj_cnt_q  <= '0;
    end else begin
      data_q     <= data_d;
      data_val_q <= data_val_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      inj_cnt_q  <= inj_cnt_d;
    end
  end

  assign o_data      = data_q;
  assign o_data_val  = data_val_q;
  assign o_grant     = grant_q;
  assign o_inj_count = inj_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_local_inject_arbiter.sv
`default_nettype none
// ============================================================================
// tb_local_inject_arbiter : directed table + sequence bench for the arbiter.
// Rev 1.0
// ============================================================================
module tb_local_inject_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [0:N-1][DW-1:0] src_data;
  logic [0:N-1]      src_val;
  logic [3:0]        net_en;
  logic [0:N-1]      src_ready, grant, src_ready4, grant4;
  logic [DW-1:0]     data, data4;
  logic              data_val, data_val4;
  logic [15:0]       inj_count;
  logic [3:0]        inj_count4;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  local_inject_arbiter #(.N_SRC(N), .FIFO_DEPTH(4), .CNT_W(16), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .i_src_data(src_data), .i_src_val(src_val),
    .o_src_ready(src_ready), .i_net_en(net_en), .o_data(data),
    .o_data_val(data_val), .o_grant(grant), .o_inj_count(inj_count)
  );

  // Narrow-counter copy sharing the same stimulus, for counter wrap.
  local_inject_arbiter #(.N_SRC(N), .FIFO_DEPTH(4), .CNT_W(4), .DATA_W(DW)) dut4 (
    .clk(clk), .reset_n(reset_n), .i_src_data(src_data), .i_src_val(src_val),
    .o_src_ready(src_ready4), .i_net_en(net_en), .o_data(data4),
    .o_data_val(data_val4), .o_grant(grant4), .o_inj_count(inj_count4)
  );

  typedef struct {
    logic [0:N-1]  val;
    logic [DW-1:0] d;
    logic [3:0]    en;
    logic          ev;
    logic [0:N-1]  eg;
    logic [DW-1:0] ed;
    logic [0:N-1]  er;
    int            ec;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic [0:N-1] val, input logic [DW-1:0] d,
                              input logic [3:0] en, input logic ev,
                              input logic [0:N-1] eg, input logic [DW-1:0] ed,
                              input int ec);
    vec_t v;
    v.val = val; v.d = d; v.en = en; v.ev = ev;
    v.eg = eg; v.ed = ed; v.er = 4'b1111; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [DW-1:0] d);
    for (int s = 0; s < N; s++) src_data[s] = d + DW'(s);
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [0:N-1] eg,
                           input logic [DW-1:0] ed, input int ec);
    logic [15:0] c16;
    logic [3:0]  c4;
    c16 = ec[15:0];
    c4  = ec[3:0];
    chk({tag, ".val"}, data_val, ev);
    chk({tag, ".grant"}, grant, eg);
    if (ev) chk({tag, ".data"}, data, ed);
    chk({tag, ".cnt"}, inj_count, c16);
    chk({tag, ".cnt4"}, inj_count4, c4);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    src_val  = '0;
    src_data = '0;
    net_en   = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    logic [0:N-1] g;

    tbl[0]  = mk(4'b0010, 32'h100, 4'b0001, 1'b0, 4'b0000, 32'h0,   0);
    tbl[1]  = mk(4'b0000, 32'h0,   4'b0001, 1'b1, 4'b0010, 32'h102, 1);
    tbl[2]  = mk(4'b0000, 32'h0,   4'b0001, 1'b0, 4'b0000, 32'h0,   1);
    tbl[3]  = mk(4'b1001, 32'h200, 4'b0000, 1'b0, 4'b0000, 32'h0,   1);
    tbl[4]  = mk(4'b1001, 32'h210, 4'b0000, 1'b0, 4'b0000, 32'h0,   1);
    tbl[5]  = mk(4'b0000, 32'h0,   4'b0001, 1'b1, 4'b0001, 32'h203, 2);
    tbl[6]  = mk(4'b0000, 32'h0,   4'b0000, 1'b0, 4'b0000, 32'h0,   2);
    tbl[7]  = mk(4'b0000, 32'h0,   4'b0100, 1'b1, 4'b1000, 32'h200, 3);
    tbl[8]  = mk(4'b0000, 32'h0,   4'b0000, 1'b0, 4'b0000, 32'h0,   3);
    tbl[9]  = mk(4'b0000, 32'h0,   4'b1000, 1'b1, 4'b0001, 32'h213, 4);
    tbl[10] = mk(4'b0000, 32'h0,   4'b0000, 1'b0, 4'b0000, 32'h0,   4);
    tbl[11] = mk(4'b0000, 32'h0,   4'b0010, 1'b1, 4'b1000, 32'h210, 5);
    tbl[12] = mk(4'b0000, 32'h0,   4'b1111, 1'b0, 4'b0000, 32'h0,   5);

    // Reset state
    do_reset();
    chk("rst.ready", src_ready, 4'b1111);
    chk("rst.data", data, 32'h0);
    check_out("rst", 1'b0, 4'b0000, 32'h0, 0);

    // Single push latency, then enable toggling with sources 0 and 3
    for (int i = 0; i < 13; i++) begin
      src_val = tbl[i].val;
      set_data(tbl[i].d);
      net_en  = tbl[i].en;
      tick();
      check_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].eg, tbl[i].ed, tbl[i].ec);
      chk($sformatf("row%0d.ready", i), src_ready, tbl[i].er);
    end

    // All four FIFOs preloaded, full-rate round-robin drain
    do_reset();
    src_val = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      for (int q = 0; q < N; q++) src_data[q] = DW'(q * 16 + s);
      tick();
    end
    chk("full.ready", src_ready, 4'b0000);
    src_val = '0;
    net_en  = 4'hF;
    for (int i = 0; i < 16; i++) begin
      tick();
      g = '0;
      g[i % 4] = 1'b1;
      check_out($sformatf("burst%0d", i), 1'b1, g, DW'((i % 4) * 16 + i / 4), i + 1);
    end
    tick();
    check_out("burst_end", 1'b0, 4'b0000, 32'h0, 16);
    src_val = 4'b1000;
    src_data[0] = 32'h99;
    tick();
    src_val = '0;
    tick();
    check_out("wrap17", 1'b1, 4'b1000, 32'h99, 17);

    // Backpressure on source 1: fifth offer must be dropped
    do_reset();
    src_val = 4'b0100;
    for (int s = 0; s < 5; s++) begin
      src_data[1] = 32'h300 + DW'(s);
      tick();
      if (s >= 3) chk($sformatf("bp.ready%0d", s), src_ready, 4'b1011);
    end
    src_val = '0;
    net_en  = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("bp%0d", i), 1'b1, 4'b0100, 32'h300 + DW'(i), i + 1);
      if (i == 0) chk("bp.ready_back", src_ready, 4'b1111);
    end
    tick();
    check_out("bp_end", 1'b0, 4'b0000, 32'h0, 4);

    // Asynchronous reset in the middle of a burst
    do_reset();
    src_val = 4'b1010;
    for (int s = 0; s < 2; s++) begin
      src_data[0] = 32'h400 + DW'(s);
      src_data[2] = 32'h420 + DW'(s);
      tick();
    end
    src_val = '0;
    net_en  = 4'hF;
    tick();
    check_out("ar.pre", 1'b1, 4'b1000, 32'h400, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("ar.data", data, 32'h0);
    chk("ar.ready", src_ready, 4'b1111);
    check_out("ar", 1'b0, 4'b0000, 32'h0, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("ar.idle%0d", i), 1'b0, 4'b0000, 32'h0, 0);
    end
    src_val = 4'b0100;
    src_data[1] = 32'h555;
    tick();
    src_val = '0;
    tick();
    check_out("ar.new", 1'b1, 4'b0100, 32'h555, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
